// File: rtl/audio_i2s_tx_pkg.sv
// Shared definitions for the MD+ I2S audio output path.
package audio_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int I2S_SLOT_W      = 32;
  localparam int I2S_FRAME_SLOTS = 64;

  typedef logic signed [SAMPLE_W-1:0] pcm_t;

  // Slots 1..SAMPLE_W of each half carry sample bits; slot 0 is the I2S one-bit delay.
  function automatic logic in_data_slot(input logic [$clog2(I2S_SLOT_W)-1:0] k);
    return (k >= 5'd1) && (k <= 5'(SAMPLE_W));
  endfunction

endpackage

// File: rtl/audio_i2s_tx_clkgen.sv
// I2S timing generator: divider, slot counter, bclk/lrck and the frame latch strobe.
// Optional DAC master clock when AUDIO_I2S_MCLK_EN is defined.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       bit_stb,
  output logic       latch,
  output logic [5:0] slot,
  output logic       bclk,
  output logic       lrck,
  output logic       mclk
);

  localparam int DW   = $clog2(BCLK_DIV);
  localparam int SW   = $clog2(I2S_FRAME_SLOTS);
  localparam int HALF = BCLK_DIV / 2;

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;
  logic [SW-1:0] slot_next;
  logic          wrap;

  always_comb begin
    wrap      = (div == DW'(BCLK_DIV - 1));
    div_next  = wrap ? '0 : div + DW'(1);
    slot_next = wrap ? slot + SW'(1) : slot;
  end

  assign bit_stb = (div == '0);
  assign latch   = bit_stb && (slot == '0);

  // bclk is registered from the next divider value so it is low exactly while div < HALF
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      slot <= '0;
      bclk <= 1'b0;
      lrck <= 1'b0;
    end else begin
      div  <= div_next;
      slot <= slot_next;
      bclk <= (div_next >= DW'(HALF));
      if (bit_stb) lrck <= slot[SW-1];
    end
  end

`ifdef AUDIO_I2S_MCLK_EN
  localparam int MQ = BCLK_DIV / 8;
  localparam int MW = (MQ > 1) ? $clog2(MQ) : 1;

  logic [MW-1:0] mcnt;
  logic          modd;

  // mclk is high in even groups of MQ divider counts, so it rises together with bclk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= '0;
      modd <= 1'b0;
      mclk <= 1'b0;
    end else if (wrap) begin
      mcnt <= '0;
      modd <= 1'b0;
      mclk <= 1'b1;
    end else if (mcnt == MW'(MQ - 1)) begin
      mcnt <= '0;
      modd <= ~modd;
      mclk <= modd;
    end else begin
      mcnt <= mcnt + MW'(1);
      mclk <= ~modd;
    end
  end
`else
  assign mclk = 1'b0;
`endif

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter for the MD+ audio pair; frame-aligned sample latch and mute.
// Define AUDIO_I2S_MCLK_EN to drive i2s_mclk at 256*fs.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] snd_l,
  input  logic signed [SAMPLE_W-1:0] snd_r,
  input  logic                       mute,
  output logic                       i2s_mclk,
  output logic                       i2s_bclk,
  output logic                       i2s_lrck,
  output logic                       i2s_sdat,
  output logic                       frame_tick
);

  logic       bit_stb;
  logic       latch;
  logic [5:0] slot;
  logic       data_slot;
  pcm_t       sreg_l;
  pcm_t       sreg_r;

  i2s_clkgen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_stb(bit_stb),
    .latch  (latch),
    .slot   (slot),
    .bclk   (i2s_bclk),
    .lrck   (i2s_lrck),
    .mclk   (i2s_mclk)
  );

  always_comb begin
    data_slot = in_data_slot(slot[4:0]);
  end

  // Mute is sampled only at the latch so a word is never cut mid-stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_l     <= '0;
      sreg_r     <= '0;
      i2s_sdat   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= latch;
      if (latch) begin
        sreg_l   <= mute ? '0 : snd_l;
        sreg_r   <= mute ? '0 : snd_r;
        i2s_sdat <= 1'b0;
      end else if (bit_stb) begin
        if (!data_slot) begin
          i2s_sdat <= 1'b0;
        end else if (slot[5]) begin
          i2s_sdat <= sreg_r[SAMPLE_W-1];
          sreg_r   <= {sreg_r[SAMPLE_W-2:0], 1'b0};
        end else begin
          i2s_sdat <= sreg_l[SAMPLE_W-1];
          sreg_l   <= {sreg_l[SAMPLE_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx at BCLK_DIV=8 (512 clks per frame).
module tb_audio_i2s_tx;

  localparam int BCLK_DIV = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] snd_l;
  logic signed [15:0] snd_r;
  logic               mute;
  logic               i2s_mclk;
  logic               i2s_bclk;
  logic               i2s_lrck;
  logic               i2s_sdat;
  logic               frame_tick;

  int compared   = 0;
  int mismatched = 0;
  int n;
  int ticks_seen;

  audio_i2s_tx #(.BCLK_DIV(BCLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .snd_l     (snd_l),
    .snd_r     (snd_r),
    .mute      (mute),
    .i2s_mclk  (i2s_mclk),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sdat  (i2s_sdat),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      n++;
      if (frame_tick) ticks_seen++;
    end
  endtask

  // Captures one 512-clk frame; bit (63-slot) holds sdat sampled mid-slot around bclk high
  task automatic capture(input int chg_at, input logic [15:0] nl, input logic nm,
                         output logic [63:0] f, output int nt, output int pos);
    f   = '0;
    nt  = 0;
    pos = -1;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      n++;
      if (frame_tick) begin
        nt++;
        if (pos < 0) pos = i;
      end
      if (i % 8 == 4) f[63 - i / 8] = i2s_sdat;
      if (i == chg_at) begin
        snd_l = nl;
        mute  = nm;
      end
    end
  endtask

  logic [63:0] fr;
  int          nt;
  int          pos;
  logic [7:0]  bpat;
  logic [7:0]  mpat;

  initial begin
    rst_n = 1'b0;
    snd_l = '0;
    snd_r = '0;
    mute  = 1'b0;
    n     = -1;
    ticks_seen = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {59'd0, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdat, frame_tick}, 64'd0);

    // Release; the next posedge is the first latch
    rst_n = 1'b1;
    adv(1);
    check("first_tick", {63'd0, frame_tick}, 64'd1);
    ticks_seen = 0;
    bpat[7] = i2s_bclk;
    for (int i = 6; i >= 0; i--) begin
      adv(1);
      bpat[i] = i2s_bclk;
    end
    check("bclk_pattern", {56'd0, bpat}, {56'd0, 8'b0001_1110});
    adv(248);
    check("lrck_n255", {63'd0, i2s_lrck}, 64'd0);
    adv(1);
    check("lrck_n256", {63'd0, i2s_lrck}, 64'd1);
    adv(255);
    check("lrck_n511", {63'd0, i2s_lrck}, 64'd1);
    check("no_tick_midframe", 64'(ticks_seen), 64'd0);

    // Extreme bit patterns
    snd_l = 16'sh8001;
    snd_r = 16'sh7FFE;
    capture(-1, 16'h8001, 1'b0, fr, nt, pos);
    check("frame_8001_7ffe", fr, {1'b0, 16'h8001, 15'h0, 1'b0, 16'h7FFE, 15'h0});
    check("tick_at_512", {32'(nt), 32'(pos)}, {32'd1, 32'd0});

    // Mid-frame input change only lands at the next latch
    snd_l = 16'sh1234;
    snd_r = 16'sh0000;
    capture(100, 16'hABCD, 1'b0, fr, nt, pos);
    check("frame_1234_held", fr, {1'b0, 16'h1234, 15'h0, 1'b0, 16'h0000, 15'h0});
    check("tick_at_1024", {32'(nt), 32'(pos)}, {32'd1, 32'd0});
    capture(-1, 16'hABCD, 1'b0, fr, nt, pos);
    check("frame_abcd_next", fr, {1'b0, 16'hABCD, 15'h0, 1'b0, 16'h0000, 15'h0});

    // Mute raised at slot 40 takes effect on the following frame
    snd_l = 16'sh5555;
    snd_r = 16'sh5555;
    capture(320, 16'h5555, 1'b1, fr, nt, pos);
    check("frame_mute_raised", fr, {1'b0, 16'h5555, 15'h0, 1'b0, 16'h5555, 15'h0});
    capture(-1, 16'h5555, 1'b1, fr, nt, pos);
    check("frame_muted", fr, 64'd0);
    check("tick_muted", {32'(nt), 32'(pos)}, {32'd1, 32'd0});
    mute = 1'b0;
    capture(-1, 16'h5555, 1'b0, fr, nt, pos);
    check("frame_unmuted", fr, {1'b0, 16'h5555, 15'h0, 1'b0, 16'h5555, 15'h0});

    // Reset mid-frame at slot 20, with bclk high
    adv(165);
    check("bclk_before_reset", {63'd0, i2s_bclk}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {59'd0, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdat, frame_tick}, 64'd0);
    repeat (3) @(negedge clk);
    check("held_reset_outputs",
          {59'd0, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdat, frame_tick}, 64'd0);
    snd_l = 16'sh8001;
    rst_n = 1'b1;
    n = -1;
    adv(1);
    check("restart_tick", {63'd0, frame_tick}, 64'd1);
    adv(7);
    check("sdat_before_msb", {63'd0, i2s_sdat}, 64'd0);
    adv(1);
    check("left_msb_8clk", {63'd0, i2s_sdat}, 64'd1);

    // Master clock over n=9..16
    for (int i = 7; i >= 0; i--) begin
      adv(1);
      bpat[i] = i2s_bclk;
      mpat[i] = i2s_mclk;
    end
    check("bclk_n9_16", {56'd0, bpat}, {56'd0, 8'h3C});
`ifdef AUDIO_I2S_MCLK_EN
    check("mclk_pattern", {56'd0, mpat}, {56'd0, 8'hAA});
    check("mclk_rise_with_bclk", {60'd0, bpat[6], mpat[6], bpat[5], mpat[5]}, {60'd0, 4'b0011});
`else
    check("mclk_tied_low", {56'd0, mpat}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serial audio output stage directly downstream of the MD+ audio block. It takes the signed 16-bit left/right PCM pair (`snd_l`/`snd_r`) and continuously serialises it as a standard Philips I2S stream for the external DAC. It generates bit clock, word select and data from the single system clock, and re-samples the input pair once per frame. Mute is applied on a frame boundary so the stream never carries partial words.

## Interface
- `BCLK_DIV`, 16: clk cycles per bit-clock period. Even, ≥4; multiple of 8 when `AUDIO_I2S_MCLK_EN` is defined.
- `clk`  in  1  system clock (same clock as the MD+ audio block).
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `snd_l`  in  16  signed left sample; may change on any cycle.
- `snd_r`  in  16  signed right sample; may change on any cycle.
- `mute`  in  1  level; forces latched samples to zero.
- `i2s_mclk`  out  1  master clock for the DAC (see Configuration).
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrck`  out  1  word select: 0 = left, 1 = right.
- `i2s_sdat`  out  1  serial data, MSB first.
- `frame_tick`  out  1  one-clk pulse when a new sample pair is latched.

## Operation
- Divider `div` counts 0..BCLK_DIV-1 and wraps.
  - `i2s_bclk` = 0 while `div` < BCLK_DIV/2, else 1.
  - The falling edge of bclk is defined as `div`==0.
- Slot counter `slot[5:0]` advances on each `div` wrap (63→0). One frame is 64 bclk: 32 slots left, then 32 slots right.
- `i2s_lrck` = `slot[5]`, registered so it changes at `div`==0.
- Latch event: `div`==0 and `slot`==0.
  - Capture `snd_l` and `snd_r` into the left/right shift registers, or 16'h0000 if `mute`=1 at that clk.
  - Pulse `frame_tick`.
- Data mapping, with k = `slot[4:0]` within each half:
  - k=0 outputs 0 (the I2S one-bit delay after lrck changes).
  - k=1..16 outputs sample bit 16-k (MSB at k=1).
  - k=17..31 output 0.
- `i2s_sdat` updates only at `div`==0 and is held stable across the following rising edge.
- Input changes between latch events have no effect on the stream.
- A `mute` change mid-frame takes effect at the next latch, never inside a word.

## Timing
- Reset (`rst_n`=0): `div`=0, `slot`=0. All outputs are 0, including `i2s_mclk`. Shift registers are cleared.
- First clk edge after release is a latch event: `frame_tick`=1 on that cycle, and the first frame starts immediately.
- Reset asserted mid-frame aborts the frame immediately; all outputs go to 0 asynchronously.
- Sample rate fs = f_clk / (64·BCLK_DIV). Example: BCLK_DIV=16 gives f_clk/1024.
- Latency from latch to left MSB on `i2s_sdat`: BCLK_DIV clks. Right MSB follows 33·BCLK_DIV clks after latch.
- `frame_tick` period is exactly 64·BCLK_DIV clks. No drift and no skipped frames.
- All outputs are registered; no combinational path from inputs to pins.

## Configuration
- `AUDIO_I2S_MCLK_EN` defined:
  - `i2s_mclk` = 256·fs, i.e. toggles every BCLK_DIV/8 clks.
  - Phase-aligned so an mclk rising edge coincides with every bclk rising edge.
- `AUDIO_I2S_MCLK_EN` undefined: `i2s_mclk` is tied 0, and the mclk counter is not synthesised.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W`=16, `I2S_SLOT_W`=32, `I2S_FRAME_SLOTS`=64.
  - typedef `pcm_t` (logic signed [15:0]).
- Sub-module `i2s_clkgen` owns the divider, slot counter, bclk/lrck/mclk generation and the latch strobe.
- The top level keeps the sample latch, mute, shift registers and sdat mux.

## Test plan
- Reset release, BCLK_DIV=8, inputs 0 → `frame_tick` at first clk, then every 512 clks. `i2s_bclk` period 8 clks; `i2s_lrck` toggles every 256 clks.
- `snd_l`=16'h8001, `snd_r`=16'h7FFE → left slots 1..16 read 1,0×14,1; right slots 1..16 read 0,1×14,0. All other slots read 0.
- `snd_l` changed mid-frame from 16'h1234 to 16'hABCD → current frame carries 16'h1234; the next frame carries 16'hABCD.
- `mute` raised at slot 40, input 16'h5555 → current frame unchanged; next frame all-zero sdat. Lowering `mute` restores data at the following latch.
- `rst_n` pulsed low for 3 clks at slot 20 → outputs 0 during reset. Restart with `frame_tick` on the first post-release clk; left MSB appears 8 clks later.
- `AUDIO_I2S_MCLK_EN`, BCLK_DIV=16 → `i2s_mclk` period 4 clks, rising edge coincident with every `i2s_bclk` rising edge. Undefined → `i2s_mclk` stays 0.
